en_tick_gen: RTL and testbench

Run/stop control and enable-pulse generator that sits directly upstream of the 0-to-9 decade counter and drives its `en` input. It synchronizes and debounces a raw push-button, toggles a run state on each accepted press, and while running emits a one-cycle `en` pulse every `DIV` clocks. The counter can then advance at a visible rate, and an operator can start and stop it from a single button.

---
 rtl/en_tick_gen_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 114 +++++++++++
 rtl/en_tick_gen.sv | 86 ++++++++
 tb/tb_en_tick_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/en_tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// en_tick_gen_pkg
// Shared types and defaults for the run/stop enable-pulse generator.
//   db_state_e      : debounce FSM state encoding
//   DEFAULT_DIV     : default enable period in clocks
//   DEFAULT_DB_CYCLES : default debounce length in synchronized samples
//   cnt_width()     : counter width helper, never narrower than 1 bit
// -----------------------------------------------------------------------------
package en_tick_gen_pkg;

  localparam int DEFAULT_DIV       = 4;
  localparam int DEFAULT_DB_CYCLES = 4;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_e;

  // $clog2(1) is 0, which would give a zero-width vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a press/release debounce FSM. A press is
// accepted once the synchronized level has been high for DB_CYCLES
// consecutive samples; a release needs the same number of low samples before
// another press can be recognised, so a held button yields exactly one strobe.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   i_btn   : raw asynchronous button level, 1 = pressed
//   o_press : one-cycle strobe, high in the cycle before the FSM enters PRESSED
// -----------------------------------------------------------------------------
module btn_debounce
  import en_tick_gen_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int              DB_W    = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            w_btn_s;
  db_state_e       r_state;
  db_state_e       w_state_nxt;
  logic [DB_W-1:0] r_db_cnt;
  logic [DB_W-1:0] w_db_cnt_nxt;

  // i_btn is asynchronous; the second flop gives the first one a full cycle
  // to resolve metastability before anything downstream looks at it.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like real hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RELEASED;
      r_db_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_db_cnt <= w_db_cnt_nxt;
    end
  end

  // The strobe is decoded combinationally so the toggle flop in the parent
  // updates on the same edge that the FSM enters PRESSED.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    o_press      = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_btn_s) begin
          w_state_nxt  = PRESS_CHK;
          w_db_cnt_nxt = DB_W'(1);
        end
      end
      PRESS_CHK: begin
        if (!w_btn_s) begin
          w_state_nxt  = RELEASED;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt  = PRESSED;
          w_db_cnt_nxt = '0;
          o_press      = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt  = RELEASE_CHK;
          w_db_cnt_nxt = DB_W'(1);
        end
      end
      RELEASE_CHK: begin
        if (w_btn_s) begin
          // A bounce back high during release is still the same press.
          w_state_nxt  = PRESSED;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt  = RELEASED;
          w_db_cnt_nxt = '0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = RELEASED;
        w_db_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/en_tick_gen.sv
// -----------------------------------------------------------------------------
// en_tick_gen
// Run/stop control and enable-pulse generator feeding a decade counter's en
// input. Each debounced button press toggles the run state; while running a
// one-cycle en pulse is produced every DIV clocks, phase-restarted from 0 on
// every start.
//
// Parameters:
//   DIV       : enable period in clocks (1..2^16)
//   DB_CYCLES : debounce length in synchronized samples (2..2^16)
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   btn_run : raw asynchronous bouncy button, 1 = pressed
//   en      : registered one-cycle enable pulse
//   running : registered run state
//
// Build option:
//   EN_TICK_GEN_AUTOSTART_EN : when defined, running resets to 1 so the
//   counter advances straight out of reset and the first press stops it.
// -----------------------------------------------------------------------------
module en_tick_gen
  import en_tick_gen_pkg::*;
#(
  parameter int DIV       = DEFAULT_DIV,
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  output logic en,
  output logic running
);

  localparam int               DIV_W    = cnt_width(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

`ifdef EN_TICK_GEN_AUTOSTART_EN
  localparam logic RUN_RST = 1'b1;
`else
  localparam logic RUN_RST = 1'b0;
`endif

  logic             w_press;
  logic             r_running;
  logic             r_en;
  logic [DIV_W-1:0] r_div_cnt;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_run),
    .o_press (w_press)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_running <= RUN_RST;
    end else if (w_press) begin
      r_running <= ~r_running;
    end
  end

  // Keyed on the pre-edge r_running: a stop landing on a terminal count still
  // lets that last pulse out, and nothing follows it. With DIV=1 DIV_LAST is 0,
  // so the counter parks at 0 and en stays high every running cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_en      <= 1'b0;
    end else if (r_running) begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
      r_en      <= (r_div_cnt == DIV_LAST);
    end else begin
      r_div_cnt <= '0;
      r_en      <= 1'b0;
    end
  end

  assign en      = r_en;
  assign running = r_running;

endmodule

// File: tb/tb_en_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_en_tick_gen
// Self-checking bench for en_tick_gen (DIV=4, DB_CYCLES=4) with a second
// DIV=1 instance sharing clock, reset and button. Inputs change on the falling
// edge; outputs are sampled 1 ns after the rising edge. Expected values come
// from the documented latencies: a press first sampled at edge t toggles
// running at t+5, and pulses follow every 4 edges after the toggle.
// -----------------------------------------------------------------------------
module tb_en_tick_gen;

  typedef struct {
    logic run;
    logic en;
    logic en1;
    logic chk1;
  } exp_t;

  typedef struct {
    logic btn;
    exp_t exp;
  } vec_t;

  localparam int NV = 106;

  logic clk;
  logic rst;
  logic btn_run;
  logic en;
  logic running;
  logic en1;
  logic running1;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];
  vec_t vecs[NV];

  en_tick_gen #(
    .DIV       (4),
    .DB_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_run (btn_run),
    .en      (en),
    .running (running)
  );

  en_tick_gen #(
    .DIV       (1),
    .DB_CYCLES (4)
  ) dut_div1 (
    .clk     (clk),
    .rst     (rst),
    .btn_run (btn_run),
    .en      (en1),
    .running (running1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one button sample, queue its expectation, then compare after the edge.
  task automatic step(input logic b, input exp_t e, input string tag);
    exp_t got;
    @(negedge clk);
    btn_run = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check({tag, "_running"}, running, got.run);
      check({tag, "_en"},      en,      got.en);
      if (got.chk1) begin
        check({tag, "_div1_running"}, running1, got.run);
        check({tag, "_div1_en"},      en1,      got.en1);
      end
    end
  endtask

  initial begin : main
    logic [8:0] bounce;
    exp_t       e;
    int         dec_cnt;
    int         pulses;

    // Raw bounce pattern 1,0,1,1,0,1,1,1,1; bit 0 is applied first.
    bounce = 9'b111101101;

    // Timeline (edge n after reset): press t=3 -> run at 8, pulses 12+4k;
    // release 23..33; bounce 34..42 with its final 4-high run at t=39 so the
    // stop lands at 44 on a terminal count; held until 95; released from 96.
    for (int n = 0; n < NV; n++) begin
      if      (n < 3)  vecs[n].btn = 1'b0;
      else if (n < 23) vecs[n].btn = 1'b1;
      else if (n < 34) vecs[n].btn = 1'b0;
      else if (n < 43) vecs[n].btn = bounce[n-34];
      else if (n < 96) vecs[n].btn = 1'b1;
      else             vecs[n].btn = 1'b0;
      vecs[n].exp.run  = (n >= 8) && (n < 44);
      vecs[n].exp.en   = (n >= 12) && (n <= 44) && (((n - 12) % 4) == 0);
      vecs[n].exp.en1  = (n >= 9) && (n <= 44);
      vecs[n].exp.chk1 = 1'b1;
    end

    // Reset held for 3 cycles with the button toggling.
    rst     = 1'b0;
    btn_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      btn_run = ~btn_run;
      @(posedge clk);
      #1;
      check("reset_en", en, 1'b0);
      check("reset_running", running, 1'b0);
      check("reset_div1_en", en1, 1'b0);
    end
    @(negedge clk);
    btn_run = 1'b0;
    rst     = 1'b1;

    for (int n = 0; n < NV; n++) begin
      step(vecs[n].btn, vecs[n].exp, $sformatf("vec%0d", n));
      if (n == 45) check("stop_div_cnt", dut.r_div_cnt, 0);
    end

    // Start again, then pull reset mid-cycle while running.
    for (int i = 0; i <= 10; i++) begin
      e.run  = (i >= 5);
      e.en   = (i == 9);
      e.en1  = 1'b0;
      e.chk1 = 1'b0;
      step(1'b1, e, $sformatf("prerst%0d", i));
    end
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_running", running, 1'b0);
    check("async_rst_en", en, 1'b0);
    check("async_rst_div_cnt", dut.r_div_cnt, 0);
    @(posedge clk);
    #1;
    check("in_rst_running", running, 1'b0);
    rst = 1'b1;

    // Button held through reset release counts as a fresh press; a downstream
    // decade counter fed by en reaches 3 after three pulses and wraps after ten.
    dec_cnt = 0;
    pulses  = 0;
    for (int i = 0; i <= 45; i++) begin
      e.run  = (i >= 5);
      e.en   = (i >= 9) && (((i - 9) % 4) == 0);
      e.en1  = 1'b0;
      e.chk1 = 1'b0;
      step(1'b1, e, $sformatf("restart%0d", i));
      if (en === 1'b1) begin
        pulses++;
        dec_cnt = (dec_cnt == 9) ? 0 : dec_cnt + 1;
      end
      if (i == 17) check("decade_after_3", dec_cnt, 3);
    end
    check("decade_pulses", pulses, 10);
    check("decade_wrap", dec_cnt, 0);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
